pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Sequencing controller for the 5-stage RISC-V pipeline.
- Consumes decoded control (MemRead/MemWrite/Branch/EhJAL/EhJALR) and register indices from the ID, EX and MEM stages.
- Drives per-stage register enables and flushes, and the data-memory request handshake.
- Resolves load-use hazards, control redirects and variable-latency memory waits, and keeps stall/flush performance counters.

Parameters:
- MAX_WAIT, 16: dmem wait cycles after which mem_timeout is raised.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- id_rs1  in  5  rs1 index of the instruction in ID
- id_rs2  in  5  rs2 index of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_MemRead  in  1  EX instruction is a load
- ex_rd  in  5  destination register of the EX instruction
- ex_branch_taken  in  1  EX branch resolved taken (Branch & condition)
- ex_EhJAL  in  1  EX instruction is JAL
- ex_EhJALR  in  1  EX instruction is JALR
- mem_MemRead  in  1  MEM stage load
- mem_MemWrite  in  1  MEM stage store
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  data memory access request
- pc_en  out  1  PC write enable
- if_id_en  out  1  IF/ID register enable
- id_ex_en  out  1  ID/EX register enable
- ex_mem_en  out  1  EX/MEM register enable
- mem_wb_en  out  1  MEM/WB register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load bubble into ID/EX
- mem_wb_flush  out  1  load bubble into MEM/WB
- mem_timeout  out  1  sticky: a dmem wait reached MAX_WAIT
- stall_cycles  out  CNT_W  cycles in which pc_en = 0
- flush_events  out  CNT_W  redirects honoured

Behaviour:
- Reset (reset = 0, async): state RUN, wait_cnt 0, mem_timeout 0, counters 0.
  - While reset = 0, all enables, flushes and dmem_req are forced to 0.
- Definitions:
  - mem_acc = mem_MemRead | mem_MemWrite.
  - redirect = ex_branch_taken | ex_EhJAL | ex_EhJALR.
  - load_use = ex_MemRead & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- dmem_req = mem_acc, in both states, combinational.
- Default outputs: all enables 1, all flushes 0.
- FSM states: RUN and MEM_WAIT.
- RUN, evaluated in priority order:
  1. mem_acc & !dmem_ready: freeze. pc/if_id/id_ex/ex_mem/mem_wb enables = 0, mem_wb_flush = 1 so WB does not repeat a write. Next state MEM_WAIT, wait_cnt <= 1.
  2. Else redirect: if_id_flush = 1, id_ex_flush = 1, all enables 1. load_use is ignored because the ID instruction is being squashed.
  3. Else load_use: pc_en = 0, if_id_en = 0, id_ex_flush = 1, others 1. Lasts exactly one cycle because EX then holds a bubble.
  4. Else: normal advance.
- A zero-wait access (dmem_ready = 1 in the same cycle as mem_acc) causes no stall.
- MEM_WAIT:
  - While !dmem_ready: outputs are the same as the RUN freeze case. wait_cnt increments and saturates at MAX_WAIT.
  - When wait_cnt == MAX_WAIT, set mem_timeout (sticky until reset) and keep waiting.
  - On dmem_ready: next state RUN. That same cycle, outputs follow RUN rules 2–4, so a redirect or load-use held during the wait is applied now.
- Simultaneous events:
  - Memory wait beats redirect and load-use. EX is frozen, so the redirect is not lost.
  - Redirect beats load-use.
- Counters:
  - stall_cycles increments each cycle with pc_en = 0 and reset = 1.
  - flush_events increments each cycle rule 2 is applied.
  - Both saturate at all-ones. Both are registered, so the value is visible the cycle after the event.
- Reset asserted mid-wait: immediate return to RUN, outputs forced low. dmem_req drops asynchronously.

Decomposition:
- pipe_ctrl_pkg holds:
  - state enum (RUN, MEM_WAIT).
  - opcode constants shared with the decoder: R_TYPE 0110011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, I_TYPE 0010011.
- One combinational sub-module, hazard_detect, computes load_use from the ID/EX fields. FSM, output muxing and counters stay in pipeline_ctrl.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1 next cycle. Repeat with ex_rd=0 -> no stall.
- Redirect: ex_EhJALR=1 together with a load_use condition -> if_id_flush=id_ex_flush=1, pc_en=1; flush_events increments by 1.
- Memory wait: mem_MemRead=1, dmem_ready low for 3 cycles then high -> dmem_req=1 for 4 cycles, enables 0 and mem_wb_flush=1 for 3 cycles, RUN on the 4th; stall_cycles=3.
- Wait plus redirect: ex_branch_taken=1 during a 2-cycle wait -> no flush while waiting; if_id_flush=id_ex_flush=1 in the dmem_ready cycle.
- Timeout: dmem_ready held low 20 cycles with MAX_WAIT=16 -> mem_timeout rises after 16 wait cycles and stays 1 after ready; cleared only by reset=0.
- Async reset mid-wait: reset=0 asserted between clock edges -> dmem_req, enables and counters go to 0 immediately; after release, state is RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller and the decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

   // Controller FSM states
   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   // Opcode constants shared with the decoder
   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] LW     = 7'b0000011;
   localparam logic [6:0] SW     = 7'b0100011;
   localparam logic [6:0] BR     = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] I_TYPE = 7'b0010011;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: ID source registers against the EX load destination.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the hazard is honoured.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   output logic       load_use
);

   logic rs1_hit;
   logic rs2_hit;

   // x0 is never a real dependency, so a load to x0 cannot create a hazard
   always_comb begin
      rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
      rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
      load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/flushes, dmem handshake, stall/flush counters.
// Latency: control outputs are combinational; counters and mem_timeout are registered.
// Backpressure: a pending dmem access freezes every stage until dmem_ready.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             ex_EhJAL,
   input  logic             ex_EhJALR,
   input  logic             mem_MemRead,
   input  logic             mem_MemWrite,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int WC_W = $clog2(MAX_WAIT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

   state_t          state;
   state_t          state_nxt;
   logic [WC_W-1:0] wait_cnt;
   logic [WC_W-1:0] wait_cnt_nxt;

   logic mem_acc;
   logic redirect;
   logic load_use;
   logic freeze;
   logic redirect_apply;

   assign mem_acc  = mem_MemRead | mem_MemWrite;
   assign redirect = ex_branch_taken | ex_EhJAL | ex_EhJALR;

   hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_mem_read (ex_MemRead),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   // Next state, wait counter and per-stage enables/flushes; reset forces everything low
   always_comb begin
      state_nxt      = state;
      wait_cnt_nxt   = wait_cnt;
      freeze         = 1'b0;
      redirect_apply = 1'b0;
      dmem_req       = mem_acc;
      pc_en          = 1'b1;
      if_id_en       = 1'b1;
      id_ex_en       = 1'b1;
      ex_mem_en      = 1'b1;
      mem_wb_en      = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      mem_wb_flush   = 1'b0;

      case (state)
         RUN: begin
            if (mem_acc && !dmem_ready) begin
               freeze       = 1'b1;
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = WC_W'(1);
            end
         end
         MEM_WAIT: begin
            if (!dmem_ready) begin
               freeze = 1'b1;
               if (wait_cnt != WC_MAX) begin
                  wait_cnt_nxt = wait_cnt + 1'b1;
               end
            end else begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
         end
      endcase

      // Memory wait outranks redirect, which outranks load-use
      if (freeze) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (redirect) begin
         redirect_apply = 1'b1;
         if_id_flush    = 1'b1;
         id_ex_flush    = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end

      if (!reset) begin
         redirect_apply = 1'b0;
         dmem_req       = 1'b0;
         pc_en          = 1'b0;
         if_id_en       = 1'b0;
         id_ex_en       = 1'b0;
         ex_mem_en      = 1'b0;
         mem_wb_en      = 1'b0;
         if_id_flush    = 1'b0;
         id_ex_flush    = 1'b0;
         mem_wb_flush   = 1'b0;
      end
   end

   // FSM state, wait counter and the sticky timeout flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (wait_cnt_nxt == WC_MAX) begin
            mem_timeout <= 1'b1;
         end
      end
   end

   // Saturating performance counters, visible the cycle after the event
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!pc_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
         if (redirect_apply && (flush_events != '1)) begin
            flush_events <= flush_events + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_MemRead;
   logic        ex_branch_taken, ex_EhJAL, ex_EhJALR;
   logic        mem_MemRead, mem_MemWrite, dmem_ready;
   logic        dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout;
   logic [31:0] stall_cycles, flush_events;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.MAX_WAIT(16), .CNT_W(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .ex_MemRead      (ex_MemRead),
      .ex_rd           (ex_rd),
      .ex_branch_taken (ex_branch_taken),
      .ex_EhJAL        (ex_EhJAL),
      .ex_EhJALR       (ex_EhJALR),
      .mem_MemRead     (mem_MemRead),
      .mem_MemWrite    (mem_MemWrite),
      .dmem_ready      (dmem_ready),
      .dmem_req        (dmem_req),
      .pc_en           (pc_en),
      .if_id_en        (if_id_en),
      .id_ex_en        (id_ex_en),
      .ex_mem_en       (ex_mem_en),
      .mem_wb_en       (mem_wb_en),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .mem_wb_flush    (mem_wb_flush),
      .mem_timeout     (mem_timeout),
      .stall_cycles    (stall_cycles),
      .flush_events    (flush_events)
   );

   // {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush}
   logic [8:0] outs;
   assign outs = {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, mem_wb_flush};

   localparam logic [8:0] O_ZERO   = 9'b0_00000_000;
   localparam logic [8:0] O_RUN    = 9'b0_11111_000;
   localparam logic [8:0] O_RUN_M  = 9'b1_11111_000;
   localparam logic [8:0] O_STALL  = 9'b0_00111_010;
   localparam logic [8:0] O_STALLM = 9'b1_00111_010;
   localparam logic [8:0] O_FLUSH  = 9'b0_11111_110;
   localparam logic [8:0] O_FLUSHM = 9'b1_11111_110;
   localparam logic [8:0] O_FREEZE = 9'b1_00000_001;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       exmr;
      logic [4:0] exrd;
      logic       br;
      logic       jal;
      logic       jalr;
      logic       mr;
      logic       mw;
      logic       rdy;
      logic [8:0] exp;
      int         dstall;
      int         dflush;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_MemRead = 1'b0; ex_rd = 5'd0;
      ex_branch_taken = 1'b0; ex_EhJAL = 1'b0; ex_EhJALR = 1'b0;
      mem_MemRead = 1'b0; mem_MemWrite = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
      ex_MemRead = v.exmr; ex_rd = v.exrd;
      ex_branch_taken = v.br; ex_EhJAL = v.jal; ex_EhJALR = v.jalr;
      mem_MemRead = v.mr; mem_MemWrite = v.mw; dmem_ready = v.rdy;
   endtask

   initial begin
      logic [31:0] s0, f0;

      //            rs1   rs2   u1 u2 exmr exrd br jal jalr mr mw rdy exp      dst dfl
      vecs[0]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, O_RUN,    0, 0};
      vecs[1]  = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0, 0, 0, O_STALL,  1, 0};
      vecs[2]  = '{5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, 0, 0, 0, O_RUN,    0, 0};
      vecs[3]  = '{5'd3, 5'd7, 1, 1, 1, 5'd7, 0, 0, 0, 0, 0, 0, O_STALL,  1, 0};
      vecs[4]  = '{5'd5, 5'd0, 0, 0, 1, 5'd5, 0, 0, 0, 0, 0, 0, O_RUN,    0, 0};
      vecs[5]  = '{5'd5, 5'd5, 1, 1, 0, 5'd5, 0, 0, 0, 0, 0, 0, O_RUN,    0, 0};
      vecs[6]  = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 1, 0, 0, 0, O_FLUSH,  0, 1};
      vecs[7]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0, 0, 0, O_FLUSH,  0, 1};
      vecs[8]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0, 0, O_FLUSH,  0, 1};
      vecs[9]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 1, O_RUN_M,  0, 0};
      vecs[10] = '{5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 0, 0, 0, 1, 1, O_STALLM, 1, 0};
      vecs[11] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 1, 0, 1, O_FLUSHM, 0, 1};

      // Reset state: outputs forced low even with a pending access
      set_idle();
      mem_MemRead = 1'b1;
      #2;
      check("rst_outs", 32'(outs), 32'(O_ZERO));
      check("rst_stall", stall_cycles, 32'd0);
      check("rst_flush", flush_events, 32'd0);
      check("rst_timeout", 32'(mem_timeout), 32'd0);
      @(negedge clk);
      set_idle();
      reset = 1'b1;

      // Table-driven single-cycle cases, each started from RUN
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         s0 = stall_cycles;
         f0 = flush_events;
         check($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_stall", i), stall_cycles - s0, 32'(vecs[i].dstall));
         check($sformatf("vec%0d_flush", i), flush_events - f0, 32'(vecs[i].dflush));
      end

      // Three-cycle load wait, ready on the fourth
      @(negedge clk);
      set_idle();
      s0 = stall_cycles;
      f0 = flush_events;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         mem_MemRead = 1'b1;
         dmem_ready  = 1'b0;
         #1;
         check($sformatf("wait3_c%0d", i), 32'(outs), 32'(O_FREEZE));
      end
      @(negedge clk);
      dmem_ready = 1'b1;
      #1;
      check("wait3_ready", 32'(outs), 32'(O_RUN_M));
      @(posedge clk);
      #1;
      check("wait3_stall", stall_cycles - s0, 32'd3);
      check("wait3_flush", flush_events - f0, 32'd0);
      @(negedge clk);
      set_idle();
      #1;
      check("wait3_run", 32'(outs), 32'(O_RUN));

      // Branch held during a two-cycle store wait is applied on ready
      s0 = stall_cycles;
      f0 = flush_events;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         mem_MemWrite = 1'b1;
         ex_branch_taken = 1'b1;
         dmem_ready = 1'b0;
         #1;
         check($sformatf("wbr_c%0d", i), 32'(outs), 32'(O_FREEZE));
      end
      @(negedge clk);
      dmem_ready = 1'b1;
      #1;
      check("wbr_ready", 32'(outs), 32'(O_FLUSHM));
      @(posedge clk);
      #1;
      check("wbr_flush", flush_events - f0, 32'd1);
      check("wbr_stall", stall_cycles - s0, 32'd2);

      // Timeout: 20 wait cycles against MAX_WAIT = 16
      @(negedge clk);
      set_idle();
      s0 = stall_cycles;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         mem_MemRead = 1'b1;
         dmem_ready  = 1'b0;
         @(posedge clk);
         #1;
         if (i == 15) check("tmo_before", 32'(mem_timeout), 32'd0);
         if (i == 16) check("tmo_at16", 32'(mem_timeout), 32'd1);
      end
      @(negedge clk);
      dmem_ready = 1'b1;
      @(posedge clk);
      #1;
      check("tmo_stall", stall_cycles - s0, 32'd20);
      @(negedge clk);
      set_idle();
      #1;
      check("tmo_sticky", 32'(mem_timeout), 32'd1);
      check("tmo_run", 32'(outs), 32'(O_RUN));

      // Asynchronous reset in the middle of a wait
      @(negedge clk);
      mem_MemRead = 1'b1;
      dmem_ready  = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("arst_outs", 32'(outs), 32'(O_ZERO));
      check("arst_stall", stall_cycles, 32'd0);
      check("arst_flush", flush_events, 32'd0);
      check("arst_timeout", 32'(mem_timeout), 32'd0);
      @(negedge clk);
      set_idle();
      reset = 1'b1;
      #1;
      check("arst_run", 32'(outs), 32'(O_RUN));
      @(posedge clk);
      #1;
      check("arst_stall_after", stall_cycles, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
